// File: rtl/mem_arbiter_pkg.sv
// Shared control-signal package: pipeline stage control typedefs plus the
// memory arbiter's state encoding and latched-request record.
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef struct packed {
    logic       alu_src;
    logic [3:0] alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic              mem_rd;
    logic              mem_wr;
    logic [MASK_W-1:0] wmask;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_wr;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    D_WAIT  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } arb_req_t;

  function automatic arb_req_t fetch_req(input logic [ADDR_W-1:0] addr);
    arb_req_t r;
    r       = '0;
    r.addr  = addr;
    return r;
  endfunction

  // Reads carry no store data and an all-zero byte mask onto the bus.
  function automatic arb_req_t data_req(input logic              we,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wdata,
                                        input logic [MASK_W-1:0] wmask);
    arb_req_t r;
    r       = '0;
    r.we    = we;
    r.addr  = addr;
    if (we) begin
      r.wdata = wdata;
      r.wmask = wmask;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and shared-memory port of the arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [MASK_W-1:0] d_wmask;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              err_spurious;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask,
           mem_ack, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, err_spurious
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask,
           mem_ack, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, err_spurious
  );

endinterface

// File: rtl/arb_req_latch.sv
// Captures the granted requester's access and steers memory read data to
// whichever port is being acknowledged.
module arb_req_latch
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              sel_data_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [MASK_W-1:0] d_wmask_i,
  input  logic              if_ack_i,
  input  logic              d_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output arb_req_t          req_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic [DATA_W-1:0] d_rdata_o
);

  arb_req_t req_q;
  arb_req_t req_d;
  arb_req_t src;

  always_comb begin
    src   = fetch_req(if_addr_i);
    req_d = req_q;
    if (sel_data_i) begin
      src = data_req(d_we_i, d_addr_i, d_wdata_i, d_wmask_i);
    end
    if (load_i) begin
      req_d = src;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end

  assign req_o      = req_q;
  assign if_rdata_o = if_ack_i ? mem_rdata_i : '0;
  assign d_rdata_o  = d_ack_i  ? mem_rdata_i : '0;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory, one access at a time,
// alternating grants under contention.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  arb_state_t state_q, state_d;
  logic       last_was_data_q, last_was_data_d;
  logic       err_q, err_d;
  logic       grant;
  logic       grant_data;
  logic       mem_req_c;
  logic       if_ack_c;
  logic       d_ack_c;
  logic       if_ack_g;
  logic       d_ack_g;
  arb_req_t   req;

  always_comb begin
    state_d         = state_q;
    last_was_data_d = last_was_data_q;
    grant           = 1'b0;
    grant_data      = 1'b0;
    mem_req_c       = 1'b0;
    if_ack_c        = 1'b0;
    d_ack_c         = 1'b0;
    err_d           = err_q;
    case (state_q)
      IDLE: begin
        err_d = err_q | bus.mem_ack;
        if (bus.d_req && (!bus.if_req || !last_was_data_q)) begin
          state_d    = D_WAIT;
          grant      = 1'b1;
          grant_data = 1'b1;
        end else if (bus.if_req) begin
          state_d = IF_WAIT;
          grant   = 1'b1;
        end
      end
      IF_WAIT: begin
        mem_req_c = 1'b1;
        if (bus.mem_ack) begin
          if_ack_c        = 1'b1;
          last_was_data_d = 1'b0;
          state_d         = IDLE;
        end
      end
      D_WAIT: begin
        mem_req_c = 1'b1;
        if (bus.mem_ack) begin
          d_ack_c         = 1'b1;
          last_was_data_d = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      last_was_data_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_was_data_q <= last_was_data_d;
      err_q           <= err_d;
    end
  end

  // Reset abandons an in-flight access in the very cycle it is asserted.
  assign if_ack_g = if_ack_c & ~reset;
  assign d_ack_g  = d_ack_c  & ~reset;

  arb_req_latch u_latch (
    .clk         (clk),
    .reset       (reset),
    .load_i      (grant),
    .sel_data_i  (grant_data),
    .if_addr_i   (bus.if_addr),
    .d_we_i      (bus.d_we),
    .d_addr_i    (bus.d_addr),
    .d_wdata_i   (bus.d_wdata),
    .d_wmask_i   (bus.d_wmask),
    .if_ack_i    (if_ack_g),
    .d_ack_i     (d_ack_g),
    .mem_rdata_i (bus.mem_rdata),
    .req_o       (req),
    .if_rdata_o  (bus.if_rdata),
    .d_rdata_o   (bus.d_rdata)
  );

  assign bus.if_ack       = if_ack_g;
  assign bus.d_ack        = d_ack_g;
  assign bus.mem_req      = mem_req_c & ~reset;
  assign bus.mem_we       = req.we;
  assign bus.mem_addr     = req.addr;
  assign bus.mem_wdata    = req.wdata;
  assign bus.mem_wmask    = req.wmask;
  assign bus.err_spurious = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, store, contention, withdrawal
// and reset during an outstanding access.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0020;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0044;
    bus.d_wdata = 32'h1234_5678; bus.d_wmask = 4'hF;
    bus.mem_ack = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    checks++; if (bus.if_ack !== 1'b0) begin errors++; $display("FAIL reset_if_ack: got %b want 0", bus.if_ack); end
    checks++; if (bus.d_ack !== 1'b0) begin errors++; $display("FAIL reset_d_ack: got %b want 0", bus.d_ack); end
    tick();
    checks++; if (bus.err_spurious !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err_spurious); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_wmask !== 4'h0 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_latch: got we=%b wmask=%h wdata=%h want all 0", bus.mem_we, bus.mem_wmask, bus.mem_wdata);
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0; bus.mem_ack = 1'b0;
    bus.d_wdata = 32'h0; bus.d_wmask = 4'h0;
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fetch_grant_mem_req: got %b want 0", bus.mem_req); end
    tick();
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL fetch_wait_mem_req: got %b want 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h0000_0010 || bus.mem_wmask !== 4'h0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL fetch_mem_fields: got addr=%h wmask=%h we=%b want 00000010/0/0", bus.mem_addr, bus.mem_wmask, bus.mem_we);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0013;
    #1;
    checks++; if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h0000_0013) begin
      errors++; $display("FAIL fetch_ack: got ack=%b rdata=%h want 1/00000013", bus.if_ack, bus.if_rdata);
    end
    checks++; if (bus.d_ack !== 1'b0 || bus.d_rdata !== 32'h0) begin
      errors++; $display("FAIL fetch_no_d_ack: got ack=%b rdata=%h want 0/0", bus.d_ack, bus.d_rdata);
    end
    tick();
    bus.if_req = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0000_0055;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.if_ack !== 1'b0 || bus.if_rdata !== 32'h0) begin
      errors++; $display("FAIL fetch_idle_after: got req=%b ack=%b rdata=%h want 0/0/0", bus.mem_req, bus.if_ack, bus.if_rdata);
    end
  endtask

  task automatic test_store();
    int acks;
    acks = 0;
    tick();
    bus.mem_rdata = 32'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0100;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_wmask = 4'hF;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL store_grant_mem_req: got %b want 0", bus.mem_req); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) begin
        bus.d_addr = 32'h0000_0200; bus.d_wdata = 32'h0; bus.d_wmask = 4'h1;
      end
      bus.mem_ack = (i == 3);
      #1;
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h0000_0100 ||
                    bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_wmask !== 4'hF) begin
        errors++; $display("FAIL store_stable[%0d]: got req=%b we=%b addr=%h wdata=%h wmask=%h want 1/1/00000100/deadbeef/f",
                           i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
      end
      checks++; if (bus.d_ack !== (i == 3)) begin errors++; $display("FAIL store_ack[%0d]: got %b want %b", i, bus.d_ack, (i == 3)); end
      if (bus.d_ack === 1'b1) acks++;
    end
    checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h want 0", bus.d_rdata); end
    tick();
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.mem_ack = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.d_ack !== 1'b0) begin
      errors++; $display("FAIL store_idle_after: got req=%b ack=%b want 0/0", bus.mem_req, bus.d_ack);
    end
    checks++; if (acks !== 1) begin errors++; $display("FAIL store_ack_count: got %0d want 1", acks); end
  endtask

  task automatic test_contention();
    int order [4];
    int done;
    int exp_order [4];
    logic prev_ack;
    exp_order = '{0, 1, 0, 1};
    done = 0;
    prev_ack = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0080;
    bus.d_wdata = 32'h0; bus.d_wmask = 4'h0;
    for (int cyc = 0; cyc < 40 && done < 4; cyc++) begin
      #1;
      if (bus.mem_req === 1'b1) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = bus.mem_addr ^ 32'h1111_0000;
      end
      #1;
      checks++; if (bus.if_ack === 1'b1 && bus.d_ack === 1'b1) begin errors++; $display("FAIL cont_dual_ack: got both acks at cycle %0d want at most one", cyc); end
      if (prev_ack) begin
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL cont_idle_gap: got mem_req=%b after ack want 0", bus.mem_req); end
      end
      if (bus.mem_req === 1'b1) begin
        checks++; if (bus.mem_wmask !== 4'h0) begin errors++; $display("FAIL cont_wmask: got %h want 0", bus.mem_wmask); end
      end
      prev_ack = bus.if_ack | bus.d_ack;
      if (bus.d_ack === 1'b1) begin
        checks++; if (bus.d_rdata !== 32'h1111_0080) begin errors++; $display("FAIL cont_d_rdata: got %h want 11110080", bus.d_rdata); end
        order[done] = 0; done++;
      end else if (bus.if_ack === 1'b1) begin
        checks++; if (bus.if_rdata !== 32'h1111_0040) begin errors++; $display("FAIL cont_if_rdata: got %h want 11110040", bus.if_rdata); end
        order[done] = 1; done++;
      end
      tick();
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 32'h0;
      if (done == 4) begin
        bus.if_req = 1'b0; bus.d_req = 1'b0;
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    checks++; if (done !== 4) begin errors++; $display("FAIL cont_timeout: got %0d completions want 4", done); end
    for (int i = 0; i < 4; i++) begin
      if (i < done) begin
        checks++; if (order[i] !== exp_order[i]) begin
          errors++; $display("FAIL cont_order[%0d]: got %s want %s", i, order[i] == 0 ? "D" : "F", exp_order[i] == 0 ? "D" : "F");
        end
      end
    end
  endtask

  task automatic test_withdraw();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0300;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL wd_grant_mem_req: got %b want 0", bus.mem_req); end
    tick();
    bus.d_req = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0300) begin
      errors++; $display("FAIL wd_wait1: got req=%b addr=%h want 1/00000300", bus.mem_req, bus.mem_addr);
    end
    tick();
    checks++; if (bus.mem_req !== 1'b1 || bus.d_ack !== 1'b0) begin
      errors++; $display("FAIL wd_wait2: got req=%b ack=%b want 1/0", bus.mem_req, bus.d_ack);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_ABCD;
    #1;
    checks++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'h0000_ABCD || bus.if_ack !== 1'b0) begin
      errors++; $display("FAIL wd_ack: got d_ack=%b rdata=%h if_ack=%b want 1/0000abcd/0", bus.d_ack, bus.d_rdata, bus.if_ack);
    end
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.d_ack !== 1'b0) begin
      errors++; $display("FAIL wd_idle: got req=%b ack=%b want 0/0", bus.mem_req, bus.d_ack);
    end
    tick();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL wd_no_regrant: got %b want 0", bus.mem_req); end
  endtask

  task automatic test_reset_mid();
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0400;
    bus.d_wdata = 32'h0000_0001; bus.d_wmask = 4'h3;
    #1;
    tick();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0400) begin
      errors++; $display("FAIL rmid_wait: got req=%b addr=%h want 1/00000400", bus.mem_req, bus.mem_addr);
    end
    reset = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.d_ack !== 1'b0) begin
      errors++; $display("FAIL rmid_reset_cycle: got req=%b ack=%b want 0/0", bus.mem_req, bus.d_ack);
    end
    tick();
    reset = 1'b0; bus.d_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0777;
    #1;
    checks++; if (bus.d_ack !== 1'b0 || bus.mem_req !== 1'b0 || bus.err_spurious !== 1'b0) begin
      errors++; $display("FAIL rmid_late_ack: got ack=%b req=%b err=%b want 0/0/0", bus.d_ack, bus.mem_req, bus.err_spurious);
    end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rmid_latch_cleared: got %h want 0", bus.mem_addr); end
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    #1;
    checks++; if (bus.err_spurious !== 1'b1 || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL rmid_err_set: got err=%b req=%b want 1/0", bus.err_spurious, bus.mem_req);
    end
    tick();
    tick();
    checks++; if (bus.err_spurious !== 1'b1) begin errors++; $display("FAIL rmid_err_sticky: got %b want 1", bus.err_spurious); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.err_spurious !== 1'b0) begin errors++; $display("FAIL rmid_err_clear: got %b want 0", bus.err_spurious); end
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0;
    bus.d_wdata = 32'h0; bus.d_wmask = 4'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_withdraw();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 if_req  in  1  fetch request, held until if_ack; if_addr  in  32  fetch word address.
REQ-003 if_ack  out  1  one-cycle fetch completion pulse; if_rdata  out  32  fetch data, valid only with if_ack.
REQ-004 d_req  in  1  data request, held until d_ack; d_we  in  1  1=write; d_addr  in  32  byte address; d_wdata  in  32  store data; d_wmask  in  4  byte enables.
REQ-005 d_ack  out  1  one-cycle data completion pulse, for reads and writes; d_rdata  out  32  load data, valid only with d_ack.
REQ-006 mem_req  out  1  shared-memory request; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32; mem_wmask  out  4 (0000 on fetch and data read).
REQ-007 mem_ack  in  1  memory completion, any latency >=0 cycles after mem_req rises; mem_rdata  in  32  read data, valid with mem_ack.
REQ-008 err_spurious  out  1  sticky flag: mem_ack seen while no transaction outstanding.
REQ-009 Parameter: none; all widths fixed.

Function
REQ-010 FSM states SHALL be IDLE, IF_WAIT, D_WAIT.
REQ-011 IDLE: no request -> stay; only if_req -> IF_WAIT; only d_req -> D_WAIT; both -> D_WAIT if last_was_data=0, else IF_WAIT.
REQ-012 On leaving IDLE, the granted requester's address/data/we/mask SHALL be latched; mem_* outputs SHALL be driven from the latch only.
REQ-013 mem_req SHALL be 1 in every IF_WAIT/D_WAIT cycle and 0 in IDLE; latched fields SHALL stay constant while mem_req=1.
REQ-014 In a *_WAIT state with mem_ack=1: the matching ack SHALL pulse in that same cycle, rdata=mem_rdata combinationally, and the state SHALL return to IDLE next cycle.
REQ-015 last_was_data SHALL update on each completion: 1 after a D_WAIT completion, 0 after an IF_WAIT completion.
REQ-016 Minimum latency req -> ack SHALL be 2 cycles (grant cycle + one wait cycle with immediate mem_ack); back-to-back transactions SHALL have >=1 IDLE cycle between them.
REQ-017 When both requesters stay asserted, grants SHALL alternate data, fetch, data, ...; neither SHALL wait more than one other transaction.
REQ-018 A requester dropping req mid-transaction SHALL NOT abort it; the memory access completes and the ack still pulses.
REQ-019 if_ack and d_ack SHALL never be 1 in the same cycle; acks SHALL be 0 in IDLE.
REQ-020 mem_ack in IDLE SHALL be ignored for acks and SHALL set err_spurious, which is cleared only by reset.
REQ-021 if_rdata/d_rdata SHALL be 0 when the corresponding ack is 0.

Reset
REQ-022 Reset SHALL force IDLE, last_was_data=0, err_spurious=0, latched fields=0; mem_req, if_ack, d_ack SHALL read 0 in the reset cycle.
REQ-023 Reset during IF_WAIT/D_WAIT SHALL abandon the transaction without ack; a mem_ack arriving the cycle after reset SHALL set err_spurious.

Structure
REQ-024 The state enum (arb_state_t) SHALL live in the shared control-signal package alongside the ex/mem/wb control typedefs.
REQ-025 The request latch plus output mux SHALL be one sub-module, arb_req_latch; FSM and fairness bit stay in mem_arbiter.

Verification
REQ-026 Fetch only: if_req=1, if_addr=0x0000_0010, mem_ack immediate with mem_rdata=0x0000_0013 -> mem_req cycle 1, if_ack + if_rdata=0x13 cycle 2, mem_wmask=0000.
REQ-027 Store: d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_wmask=1111, mem_ack after 3 wait cycles -> mem_* stable 4 cycles, single d_ack, d_rdata=0.
REQ-028 Contention: if_req and d_req held for 4 transactions from reset -> grant order D, F, D, F, never simultaneous acks.
REQ-029 Withdrawal: d_req dropped the cycle after grant -> memory access completes, d_ack pulses once, then IDLE.
REQ-030 Reset mid-D_WAIT, then mem_ack next cycle -> no d_ack, mem_req=0, err_spurious=1 until next reset.
